// File: rtl/fifo_wptr_full_if.sv
// Write-side control bundle between the external writer, the read-side
// pointer source and the FIFO memory wrapper.
interface fifo_wptr_full_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              w_en;
   logic [ADDR_W:0]   r_ptr;
   logic              w_ovf_clr;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W:0]   w_ptr;
   logic              w_full;
   logic              w_almost_full;
   logic [ADDR_W:0]   w_count;
   logic              w_overflow;

   // Environment side: writer request, read pointer, overflow clear.
   modport master (
      output w_en, r_ptr, w_ovf_clr,
      input  w_addr, w_ptr, w_full, w_almost_full, w_count, w_overflow
   );

   // Pointer/flag logic side.
   modport slave (
      input  w_en, r_ptr, w_ovf_clr,
      output w_addr, w_ptr, w_full, w_almost_full, w_count, w_overflow
   );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status logic of a dual-clock FIFO: binary RAM
// address, Gray write pointer, 2-flop read-pointer synchroniser, and
// registered full / almost-full / occupancy / sticky overflow flags.
module fifo_wptr_full #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = 14
) (
   input logic                 w_clk,
   input logic                 w_rst_n,
   fifo_wptr_full_if.slave     bus
);

   localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(AF_LEVEL);

   logic [ADDR_W:0] wbin;
   logic [ADDR_W:0] wbin_next;
   logic [ADDR_W:0] gray_next;
   logic [ADDR_W:0] w_ptr;
   logic [ADDR_W:0] rq1;
   logic [ADDR_W:0] rq2;
   logic [ADDR_W:0] rbin;
   logic [ADDR_W:0] occ_next;
   logic [ADDR_W:0] full_ptr;
   logic [ADDR_W:0] w_count;
   logic            w_full;
   logic            w_almost_full;
   logic            w_overflow;
   logic            accept;

   // Pointer advance: a write is taken only while not full.
   always_comb begin
      accept    = bus.w_en & ~w_full;
      wbin_next = accept ? wbin + 1'b1 : wbin;
      gray_next = (wbin_next >> 1) ^ wbin_next;
   end

   // Decode synchronised read pointer and derive next-cycle status terms.
   always_comb begin
      rbin = '0;
      for (int unsigned i = 0; i <= ADDR_W; i++) begin
         rbin[i] = ^(rq2 >> i);
      end
      occ_next = wbin_next - rbin;
      // Full when the write pointer is exactly one lap ahead: in Gray form
      // that is the read pointer with its two MSBs inverted.
      full_ptr = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
   end

   // Pointer registers and read-pointer synchroniser.
   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         wbin  <= '0;
         w_ptr <= '0;
         rq1   <= '0;
         rq2   <= '0;
      end else begin
         wbin  <= wbin_next;
         w_ptr <= gray_next;
         rq1   <= bus.r_ptr;
         rq2   <= rq1;
      end
   end

   // Status flags, all registered from next-state pointer values.
   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_count       <= '0;
      end else begin
         w_full        <= (gray_next == full_ptr);
         w_almost_full <= (occ_next >= AF_THRESH);
         w_count       <= occ_next;
      end
   end

   // Sticky overflow; a set in the same cycle as a clear takes priority.
   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         w_overflow <= 1'b0;
      end else if (bus.w_en && w_full) begin
         w_overflow <= 1'b1;
      end else if (bus.w_ovf_clr) begin
         w_overflow <= 1'b0;
      end
   end

   assign bus.w_addr        = wbin[ADDR_W-1:0];
   assign bus.w_ptr         = w_ptr;
   assign bus.w_full        = w_full;
   assign bus.w_almost_full = w_almost_full;
   assign bus.w_count       = w_count;
   assign bus.w_overflow    = w_overflow;

endmodule
